// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NREQ
// write-back requesters; registers the winning write as index, one-hot enable and data.
module regfile_write_arbiter #(
   parameter int NREQ        = 4,
   parameter int BINBUSWIDTH = 5,
   parameter int DATAWIDTH   = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NREQ-1:0]                 req_valid,
   output logic [NREQ-1:0]                 req_ready,
   input  logic [NREQ*BINBUSWIDTH-1:0]     req_addr,
   input  logic [NREQ*DATAWIDTH-1:0]       req_data,
   input  logic                            hold,
   output logic                            wr_en,
   output logic [BINBUSWIDTH-1:0]          wr_addr,
   output logic [(2**BINBUSWIDTH)-1:0]     wr_onehot,
   output logic [DATAWIDTH-1:0]            wr_data,
   output logic [$clog2(NREQ)-1:0]         grant_id
);

   localparam int IDW   = $clog2(NREQ);
   localparam int NREGS = 2**BINBUSWIDTH;

   logic [IDW-1:0]         ptr_q, ptr_d;
   logic                   wr_en_q, wr_en_d;
   logic [BINBUSWIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [NREGS-1:0]       wr_onehot_q, wr_onehot_d;
   logic [DATAWIDTH-1:0]   wr_data_q, wr_data_d;
   logic [IDW-1:0]         grant_id_q, grant_id_d;

   logic                   found;
   logic [IDW-1:0]         gnt;
   logic                   xfer;
   logic [BINBUSWIDTH-1:0] sel_addr;
   logic [DATAWIDTH-1:0]   sel_data;

   // First valid requester at or after the pointer, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gnt   = IDW'(idx);
         end
      end
   end

   assign xfer     = found && !hold;
   assign sel_addr = req_addr[int'(gnt)*BINBUSWIDTH +: BINBUSWIDTH];
   assign sel_data = req_data[int'(gnt)*DATAWIDTH +: DATAWIDTH];

   always_comb begin
      req_ready = '0;
      if (xfer && rst_n) req_ready[gnt] = 1'b1;
   end

   always_comb begin
      ptr_d       = ptr_q;
      wr_en_d     = 1'b0;
      wr_onehot_d = '0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      grant_id_d  = grant_id_q;
      if (xfer) begin
         ptr_d      = (int'(gnt) == NREQ-1) ? '0 : IDW'(int'(gnt) + 1);
         wr_addr_d  = sel_addr;
         wr_data_d  = sel_data;
         grant_id_d = gnt;
         // x0 writes complete the handshake but never reach the register file.
         if (sel_addr != '0) begin
            wr_en_d               = 1'b1;
            wr_onehot_d[sel_addr] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_onehot_q <= '0;
         wr_data_q   <= '0;
         grant_id_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_onehot_q <= wr_onehot_d;
         wr_data_q   <= wr_data_d;
         grant_id_q  <= grant_id_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_onehot = wr_onehot_q;
   assign wr_data   = wr_data_q;
   assign grant_id  = grant_id_q;

endmodule
